// File: rtl/ws2812b_frame_ctrl.sv
// Frame sequencer for the WS2812B serial driver: local GRB pixel buffer streamed over valid/ready.
// Optional global brightness scaling is compiled in when WS2812B_BRIGHTNESS_EN is defined.
module ws2812b_frame_ctrl #(
   parameter int unsigned NUM_LEDS = 16,
   parameter int unsigned IDX_W    = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_addr,
   input  logic [23:0]      wr_data,
   input  logic             start,
   input  logic [IDX_W-1:0] count,
   input  logic [7:0]       brightness,
   output logic             busy,
   output logic             done,
   output logic [23:0]      pix_data,
   output logic             pix_valid,
   output logic             pix_latch,
   input  logic             pix_ready
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      OFFER = 2'd2,
      DRAIN = 2'd3
   } state_t;

   // Buffer spans the full index range so any IDX_W-bit index is in bounds;
   // entries at or above NUM_LEDS are never written and stay at zero.
   localparam int unsigned      DEPTH = 1 << IDX_W;
   localparam logic [IDX_W-1:0] LEDS  = IDX_W'(NUM_LEDS);
   localparam logic [IDX_W-1:0] ONE   = IDX_W'(1);

   state_t           state, state_nxt;
   logic [23:0]      pix_buf [DEPTH];
   logic [IDX_W-1:0] idx, idx_nxt;
   logic [IDX_W-1:0] last, last_nxt;
   logic             busy_nxt, done_nxt, valid_nxt, latch_nxt;
   logic [23:0]      data_nxt;
   logic [23:0]      load_val;
   logic             xfer;

   assign xfer = pix_valid & pix_ready;

`ifdef WS2812B_BRIGHTNESS_EN
   function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
      logic [15:0] prod;
      prod = {8'h00, c} * ({8'h00, b} + 16'd1);
      return prod[15:8];
   endfunction

   always_comb begin
      load_val = {scale_ch(pix_buf[idx][23:16], brightness),
                  scale_ch(pix_buf[idx][15:8],  brightness),
                  scale_ch(pix_buf[idx][7:0],   brightness)};
   end
`else
   logic unused_brightness;
   assign unused_brightness = ^brightness;

   always_comb begin
      load_val = pix_buf[idx];
   end
`endif

   // Pixel buffer: host writes land in any state; out-of-range addresses are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            pix_buf[i] <= '0;
         end
      end else if (wr_en && (wr_addr < LEDS)) begin
         pix_buf[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         last      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pix_valid <= 1'b0;
         pix_latch <= 1'b0;
         pix_data  <= '0;
      end else begin
         state     <= state_nxt;
         idx       <= idx_nxt;
         last      <= last_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         pix_valid <= valid_nxt;
         pix_latch <= latch_nxt;
         pix_data  <= data_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start && (count != '0)) state_nxt = LOAD;
         LOAD:    state_nxt = OFFER;
         OFFER:   if (xfer) state_nxt = (idx == last) ? DRAIN : LOAD;
         DRAIN:   if (pix_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      idx_nxt   = idx;
      last_nxt  = last;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      valid_nxt = pix_valid;
      latch_nxt = pix_latch;
      data_nxt  = pix_data;
      case (state)
         IDLE: begin
            if (start) begin
               if (count == '0) begin
                  done_nxt = 1'b1;
               end else begin
                  last_nxt = ((count > LEDS) ? LEDS : count) - ONE;
                  idx_nxt  = '0;
                  busy_nxt = 1'b1;
               end
            end
         end
         LOAD: begin
            data_nxt  = load_val;
            latch_nxt = (idx == last);
            valid_nxt = 1'b1;
         end
         OFFER: begin
            if (xfer) begin
               valid_nxt = 1'b0;
               latch_nxt = 1'b0;
               if (idx != last) idx_nxt = idx + ONE;
            end
         end
         DRAIN: begin
            if (pix_ready) begin
               done_nxt = 1'b1;
               busy_nxt = 1'b0;
            end
         end
         default: begin
            idx_nxt   = '0;
            last_nxt  = '0;
            busy_nxt  = 1'b0;
            valid_nxt = 1'b0;
            latch_nxt = 1'b0;
            data_nxt  = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_ws2812b_frame_ctrl.sv
// Self-checking bench for ws2812b_frame_ctrl: transaction-level model plus literal pins.
// Expected brightness results follow WS2812B_BRIGHTNESS_EN when the bench is built with it.
module tb_ws2812b_frame_ctrl;

   logic        clk, rst, wr_en, start, pix_ready;
   logic [4:0]  wr_addr, count;
   logic [23:0] wr_data;
   logic [7:0]  brightness;
   logic        busy, done, pix_valid, pix_latch;
   logic [23:0] pix_data;

   ws2812b_frame_ctrl #(.NUM_LEDS(16), .IDX_W(5)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .count(count), .brightness(brightness),
      .busy(busy), .done(done), .pix_data(pix_data), .pix_valid(pix_valid),
      .pix_latch(pix_latch), .pix_ready(pix_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int tests = 0;
   int fails = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic logic [23:0] exp_pix(input logic [23:0] v, input logic [7:0] b);
`ifdef WS2812B_BRIGHTNESS_EN
      int g, r, bl;
      g  = int'(v[23:16]) * (int'(b) + 1) / 256;
      r  = int'(v[15:8])  * (int'(b) + 1) / 256;
      bl = int'(v[7:0])   * (int'(b) + 1) / 256;
      return {g[7:0], r[7:0], bl[7:0]};
`else
      return v;
`endif
   endfunction

   // Model state: what the outputs must be on the next cycle
   logic [23:0] mbuf [16];
   logic [24:0] xlog [$];
   logic        armed, m_busy, m_done, m_drain, m_quiet, seen_xfer;
   int          offer_idx, m_last;
   logic        pend_en;
   int          pend_addr;
   logic [23:0] pend_data;
   logic        p_valid, p_ready, p_rst, p_latch;
   logic [23:0] p_data;
   logic [7:0]  p_bri;
   int          rdy_mode = 0;

   initial begin
      armed = 0; m_busy = 0; m_done = 0; m_drain = 0; m_quiet = 0; seen_xfer = 0;
      offer_idx = 0; m_last = 0; pend_en = 0; pend_addr = 0; pend_data = '0;
      p_valid = 0; p_ready = 0; p_rst = 1; p_latch = 0; p_data = '0; p_bri = '0;
      for (int i = 0; i < 16; i++) mbuf[i] = '0;
      forever begin
         @(negedge clk);
         if (armed) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            if (m_quiet) chk("valid_after_rst", pix_valid, 0);
            if (p_valid && !p_ready && !p_rst) begin
               chk("hold_valid", pix_valid, 1);
               chk("hold_data", pix_data, p_data);
               chk("hold_latch", pix_latch, p_latch);
            end
            if (pix_valid && !p_valid) begin
               chk("offer_in_frame", m_busy && !m_drain, 1);
               chk("pix_data", pix_data, exp_pix(mbuf[offer_idx], p_bri));
               chk("pix_latch", pix_latch, offer_idx == m_last);
            end
         end
         // predict next cycle
         seen_xfer = pix_valid && pix_ready && !rst;
         m_done = 0;
         m_quiet = 0;
         if (pend_en) mbuf[pend_addr] = pend_data;
         if (rst) begin
            armed = 1; m_busy = 0; m_drain = 0; m_quiet = 1; offer_idx = 0;
            for (int i = 0; i < 16; i++) mbuf[i] = '0;
         end else if (armed) begin
            if (m_drain) begin
               if (pix_ready) begin
                  m_done = 1; m_busy = 0; m_drain = 0;
               end
            end else if (m_busy) begin
               if (seen_xfer) begin
                  xlog.push_back({pix_latch, pix_data});
                  if (offer_idx == m_last) m_drain = 1;
                  offer_idx++;
               end
            end else if (start) begin
               if (count == 0) m_done = 1;
               else begin
                  m_busy = 1;
                  m_last = ((count > 16) ? 16 : int'(count)) - 1;
                  offer_idx = 0;
               end
            end
         end
         pend_en   = !rst && wr_en && (wr_addr < 16);
         pend_addr = int'(wr_addr);
         pend_data = wr_data;
         p_valid = pix_valid; p_ready = pix_ready; p_rst = rst;
         p_data = pix_data; p_latch = pix_latch; p_bri = brightness;
      end
   end

   // Ready driver: mode 0 always ready, 1 low for 3 cycles after each transfer, 2 held low
   initial begin
      int lowcnt;
      lowcnt = 0;
      pix_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (rdy_mode == 2) pix_ready = 1'b0;
         else begin
            if (rdy_mode == 1 && seen_xfer) lowcnt = 3;
            if (lowcnt > 0) begin
               pix_ready = 1'b0;
               lowcnt--;
            end else pix_ready = 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [23:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic start_frame(input logic [4:0] c);
      start = 1'b1; count = c;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      int n;
      n = 0;
      while (done !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      chk(name, done, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, n;
      logic [24:0] e;
      logic [23:0] exp6 [3];
      logic [7:0]  bri6 [3];
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      start = 1'b0; count = '0; brightness = 8'd255;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", pix_valid, 0);
      chk("rst_latch", pix_latch, 0);
      chk("rst_data", pix_data, 0);

      // 1: three pixels with ready gaps
      wr(5'd0, 24'hFF0000); wr(5'd1, 24'h00FF00); wr(5'd2, 24'h0000FF);
      rdy_mode = 1;
      base = xlog.size();
      start_frame(5'd3);
      chk("t1_valid_early", pix_valid, 0);
      tick();
      chk("t1_valid_rise", pix_valid, 1);
      chk("t1_busy", busy, 1);
      wait_done(100, "t1_done");
      chk("t1_count", xlog.size(), base + 3);
      e = xlog[base];     chk("t1_px0", e, {1'b0, 24'hFF0000});
      e = xlog[base + 1]; chk("t1_px1", e, {1'b0, 24'h00FF00});
      e = xlog[base + 2]; chk("t1_px2", e, {1'b1, 24'h0000FF});

      // 4: writes during a frame, plus out-of-range write
      base = xlog.size();
      start_frame(5'd4);
      n = 0;
      while (xlog.size() < base + 2 && n < 100) begin tick(); n++; end
      chk("t4_two_xfers", n < 100, 1);
      wr(5'd0, 24'h111111); wr(5'd3, 24'h333333); wr(5'd20, 24'hABCDEF);
      wait_done(100, "t4_done");
      e = xlog[base];     chk("t4_px0_old", e, {1'b0, 24'hFF0000});
      e = xlog[base + 3]; chk("t4_px3_new", e, {1'b1, 24'h333333});

      // 2: count=0 then clamped count=31
      rdy_mode = 0;
      start_frame(5'd0);
      chk("t2_zero_done", done, 1);
      chk("t2_zero_busy", busy, 0);
      tick();
      chk("t2_zero_done_drop", done, 0);
      base = xlog.size();
      start_frame(5'd31);
      wait_done(200, "t2_done");
      chk("t2_count", xlog.size(), base + 16);
      e = xlog[base];      chk("t2_px0", e, {1'b0, 24'h111111});
      e = xlog[base + 3];  chk("t2_px3", e, {1'b0, 24'h333333});
      e = xlog[base + 14]; chk("t2_px14", e, {1'b0, 24'h000000});
      e = xlog[base + 15]; chk("t2_px15", e, {1'b1, 24'h000000});

      // 3: long stall with an ignored start
      rdy_mode = 2;
      base = xlog.size();
      start_frame(5'd2);
      repeat (25) tick();
      start_frame(5'd1);
      repeat (25) tick();
      chk("t3_valid_held", pix_valid, 1);
      chk("t3_no_xfer", xlog.size(), base);
      rdy_mode = 0;
      wait_done(100, "t3_done");
      chk("t3_count", xlog.size(), base + 2);

      // 5: reset during offer of pixel 2
      rdy_mode = 1;
      base = xlog.size();
      start_frame(5'd4);
      n = 0;
      while (!(pix_valid && xlog.size() == base + 2) && n < 100) begin tick(); n++; end
      chk("t5_offer2", n < 100, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_valid", pix_valid, 0);
      chk("t5_busy", busy, 0);
      chk("t5_done", done, 0);
      tick();
      rdy_mode = 0;
      base = xlog.size();
      start_frame(5'd1);
      wait_done(100, "t5_done_frame");
      chk("t5_count", xlog.size(), base + 1);
      e = xlog[base]; chk("t5_cleared", e, {1'b1, 24'h000000});

      // 6: brightness
      bri6[0] = 8'd127; bri6[1] = 8'd255; bri6[2] = 8'd0;
`ifdef WS2812B_BRIGHTNESS_EN
      exp6[0] = 24'h7F4020; exp6[1] = 24'hFF8040; exp6[2] = 24'h000000;
`else
      exp6[0] = 24'hFF8040; exp6[1] = 24'hFF8040; exp6[2] = 24'hFF8040;
`endif
      wr(5'd0, 24'hFF8040);
      for (int k = 0; k < 3; k++) begin
         brightness = bri6[k];
         base = xlog.size();
         start_frame(5'd1);
         wait_done(100, "t6_done");
         chk("t6_count", xlog.size(), base + 1);
         e = xlog[base];
         chk("t6_pix", e, {1'b1, exp6[k]});
      end

      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
